// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings, FSM state type and op-class helper for alu_seq
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - one-bit-per-cycle unsigned shift-add multiply and restoring divide
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);

    // acc: product sum or partial remainder; opa: multiplicand or dividend/quotient; opb: multiplier or divisor
    logic             busy;
    logic             is_div;
    logic             is_rem;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] acc, opa, opb;
    logic [WIDTH-1:0] acc_n, opa_n, opb_n;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic             fits;

    always_comb begin
        rem_sh   = {acc, opa[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb};
        fits     = ~rem_diff[WIDTH];
        acc_n    = acc;
        opa_n    = opa;
        opb_n    = opb;
        if (is_div) begin
            acc_n = fits ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            opa_n = {opa[WIDTH-2:0], fits};
        end else begin
            acc_n = opb[0] ? acc + opa : acc;
            opa_n = opa << 1;
            opb_n = opb >> 1;
        end
    end

    // done and result describe the iteration that completes on this clock edge
    assign done   = busy && (cnt == LAST);
    assign result = (is_div && !is_rem) ? opa_n : acc_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            is_div <= 1'b0;
            is_rem <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            is_div <= (op == OP_DIVU) || (op == OP_REMU);
            is_rem <= (op == OP_REMU);
            cnt    <= '0;
            acc    <= '0;
            opa    <= a;
            opb    <= b;
        end else if (busy) begin
            acc <= acc_n;
            opa <= opa_n;
            opb <= opb_n;
            if (cnt == LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked multi-cycle ALU; ALU_MULDIV_EN enables MULU/DIVU/REMU
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_operand1,
    input  logic [WIDTH-1:0] i_operand2,
    input  logic [3:0]       i_ALUControl,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_illegal
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state, state_n;
    logic             load;
    logic [WIDTH-1:0] ld_res, sc_res;
    logic             ld_carry, ld_ovf, ld_ill;
    logic             sc_carry, sc_ovf, sc_ill;
    logic [WIDTH:0]   sum, dif;
    logic [SHW-1:0]   shamt;

    always_comb begin
        sum      = {1'b0, i_operand1} + {1'b0, i_operand2};
        dif      = {1'b0, i_operand1} - {1'b0, i_operand2};
        shamt    = i_operand2[SHW-1:0];
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_ill   = 1'b0;
        case (i_ALUControl)
            OP_AND: sc_res = i_operand1 & i_operand2;
            OP_OR:  sc_res = i_operand1 | i_operand2;
            OP_XOR: sc_res = i_operand1 ^ i_operand2;
            OP_ADD: begin
                sc_res   = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = (i_operand1[WIDTH-1] == i_operand2[WIDTH-1]) &&
                           (sum[WIDTH-1] != i_operand1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = dif[WIDTH-1:0];
                sc_carry = ~dif[WIDTH];
                sc_ovf   = (i_operand1[WIDTH-1] != i_operand2[WIDTH-1]) &&
                           (dif[WIDTH-1] != i_operand1[WIDTH-1]);
            end
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(i_operand1) < $signed(i_operand2))};
            OP_SHL: sc_res = i_operand1 << shamt;
            OP_SHR: sc_res = i_operand1 >> shamt;
            OP_SRA: sc_res = $signed(i_operand1) >>> shamt;
`ifdef ALU_MULDIV_EN
            OP_MULU, OP_DIVU, OP_REMU: sc_res = '0;
`endif
            default: sc_ill = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_res;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .start  (md_start),
        .op     (i_ALUControl),
        .a      (i_operand1),
        .b      (i_operand2),
        .done   (md_done),
        .result (md_res)
    );
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        ld_res   = sc_res;
        ld_carry = sc_carry;
        ld_ovf   = sc_ovf;
        ld_ill   = sc_ill;
`ifdef ALU_MULDIV_EN
        md_start = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_n = DONE;
                    load    = 1'b1;
`ifdef ALU_MULDIV_EN
                    if (is_multicycle(i_ALUControl)) begin
                        state_n  = CALC;
                        load     = 1'b0;
                        md_start = 1'b1;
                    end
`endif
                end
            end
`ifdef ALU_MULDIV_EN
            CALC: begin
                // engine result is loaded on the same edge as its last iteration
                if (md_done) begin
                    state_n  = DONE;
                    load     = 1'b1;
                    ld_res   = md_res;
                    ld_carry = 1'b0;
                    ld_ovf   = 1'b0;
                    ld_ill   = 1'b0;
                end
            end
`endif
            DONE: if (i_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_result   <= '0;
            o_zero     <= 1'b0;
            o_neg      <= 1'b0;
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
            o_illegal  <= 1'b0;
        end else if (load) begin
            o_result   <= ld_res;
            o_zero     <= (ld_res == '0);
            o_neg      <= ld_res[WIDTH-1];
            o_carry    <= ld_carry;
            o_overflow <= ld_ovf;
            o_illegal  <= ld_ill;
        end
    end

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed-vector bench for alu_seq with a reference model and scoreboard
module tb_alu_seq;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_operand1 = '0;
    logic [31:0] i_operand2 = '0;
    logic [3:0]  i_ALUControl = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_result;
    logic        o_zero, o_neg, o_carry, o_overflow, o_illegal;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    alu_seq #(.WIDTH(32)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_operand1   (i_operand1),
        .i_operand2   (i_operand2),
        .i_ALUControl (i_ALUControl),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result     (o_result),
        .o_zero       (o_zero),
        .o_neg        (o_neg),
        .o_carry      (o_carry),
        .o_overflow   (o_overflow),
        .o_illegal    (o_illegal)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        z, n, c, v, ill;
        int          lat;
        int          acc_edge;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, s;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        e.res = 0; e.c = 0; e.v = 0; e.ill = 0; e.lat = 1; e.acc_edge = 0;
        case (op)
            4'h0: e.res = a & b;
            4'h1: e.res = a | b;
            4'h3: e.res = a ^ b;
            4'h2: begin
                e.res = 32'(ua + ub);
                e.c   = (ua + ub) >= 64'h1_0000_0000;
                s     = sa + sb;
                e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h6: begin
                e.res = a - b;
                e.c   = (a >= b);
                s     = sa - sb;
                e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'h7: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'h8: e.res = a << b[4:0];
            4'h9: e.res = a >> b[4:0];
            4'hA: e.res = 32'(sa >>> b[4:0]);
            4'hC: if (MD) begin e.res = 32'(ua * ub); e.lat = 33; end else e.ill = 1;
            4'hE: if (MD) begin e.res = (b == 0) ? 32'hFFFF_FFFF : a / b; e.lat = 33; end else e.ill = 1;
            4'hF: if (MD) begin e.res = (b == 0) ? a : a % b; e.lat = 33; end else e.ill = 1;
            default: e.ill = 1;
        endcase
        if (e.ill) e.res = 0;
        e.z = (e.res == 0);
        e.n = e.res[31];
        return e;
    endfunction

    exp_t q[$];
    bit   seen = 0;

    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst_n) begin
            q.delete();
            seen = 0;
        end else begin
            if (q.size() != 0) chk("busy_ready", {31'b0, o_ready}, 32'd0);
            if (o_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", {31'b0, o_valid}, 32'd0);
                end else begin
                    e = q[0];
                    if (!seen) begin
                        chk("latency", cyc - e.acc_edge + 1, e.lat);
                        seen = 1;
                    end
                    chk("result", o_result, e.res);
                    chk("flags", {27'b0, o_zero, o_neg, o_carry, o_overflow, o_illegal},
                        {27'b0, e.z, e.n, e.c, e.v, e.ill});
                    if (i_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end
            if (i_valid && o_ready) begin
                e = model(i_ALUControl, i_operand1, i_operand2);
                e.acc_edge = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // lflags = {zero, neg, carry, overflow, illegal}, hand-computed for the enabled build
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lit, input logic [4:0] lflags, input bit md,
                       input int dly, input bit junk);
        int t;
        logic [31:0] xres;
        logic [4:0]  xfl;
        t = 0;
        while (!o_ready && t < 100) begin tick(); t++; end
        chk("idle_wait", {31'b0, o_ready}, 32'd1);
        i_ALUControl = op; i_operand1 = a; i_operand2 = b; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        if (junk) begin
            for (int k = 0; k < 3; k++) begin
                i_valid = 1'b1; i_ALUControl = 4'h0;
                i_operand1 = $urandom; i_operand2 = $urandom;
                tick();
            end
            i_valid = 1'b0;
        end
        t = 0;
        while (!o_valid && t < 100) begin tick(); t++; end
        chk("valid_wait", {31'b0, o_valid}, 32'd1);
        xres = (md && !MD) ? 32'd0 : lit;
        xfl  = (md && !MD) ? 5'b10001 : lflags;
        chk("lit_result", o_result, xres);
        chk("lit_flags", {27'b0, o_zero, o_neg, o_carry, o_overflow, o_illegal}, {27'b0, xfl});
        repeat (dly) tick();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_outs", {o_result[26:0], o_zero, o_neg, o_carry, o_overflow, o_illegal}, 32'd0);
        @(posedge i_clk); #1; i_rst_n = 1'b1;
        tick();
        chk("rst_ready", {31'b0, o_ready}, 32'd1);

        run(4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 5'b00000, 0, 0, 0);
        run(4'h1, 32'h12340000, 32'h00005678, 32'h12345678, 5'b00000, 0, 1, 0);
        run(4'h3, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 5'b01000, 0, 0, 0);
        run(4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100, 0, 0, 0);
        run(4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010, 0, 0, 0);
        run(4'h6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00110, 0, 0, 0);
        run(4'h6, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 5'b01000, 0, 2, 0);
        run(4'h7, 32'hFFFFFFF0, 32'h00000001, 32'h00000001, 5'b00000, 0, 0, 0);
        run(4'hA, 32'hFFFFFFF0, 32'h00000001, 32'hFFFFFFF8, 5'b01000, 0, 0, 0);
        run(4'hA, 32'h80000001, 32'h00000000, 32'h80000001, 5'b01000, 0, 0, 0);
        run(4'h8, 32'h00000001, 32'd36,       32'h00000010, 5'b00000, 0, 0, 0);
        run(4'h9, 32'h80000000, 32'd31,       32'h00000001, 5'b00000, 0, 0, 0);
        run(4'h4, 32'h12345678, 32'h1,        32'h00000000, 5'b10001, 0, 0, 0);
        run(4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'b10001, 0, 0, 0);
        run(4'hC, 32'h00010000, 32'h00010003, 32'h00030000, 5'b00000, 1, 5, 1);
        run(4'hE, 32'd100,      32'd7,        32'd14,       5'b00000, 1, 0, 0);
        run(4'hF, 32'd100,      32'd7,        32'd2,        5'b00000, 1, 0, 0);
        run(4'hE, 32'd5,        32'd0,        32'hFFFFFFFF, 5'b01000, 1, 0, 0);
        run(4'hF, 32'd5,        32'd0,        32'd5,        5'b00000, 1, 0, 0);
        run(4'h2, 32'h00000003, 32'h00000004, 32'h00000007, 5'b00000, 0, 5, 0);

        // reset while a multiply is in flight
        i_ALUControl = 4'hC; i_operand1 = 32'd3; i_operand2 = 32'd5; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        repeat (5) tick();
        i_rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, o_valid}, 32'd0);
        chk("midrst_outs", {o_result[26:0], o_zero, o_neg, o_carry, o_overflow, o_illegal}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("midrst_ready", {31'b0, o_ready}, 32'd1);
        chk("midrst_novalid", {31'b0, o_valid}, 32'd0);

        run(4'h0, 32'hFFFFFFFF, 32'h0000FFFF, 32'h0000FFFF, 5'b00000, 0, 0, 0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
